// File: rtl/poly_pkg.sv
// Shared definitions for the polynomial unload path.
//   WID    : coefficient width in bits
//   RDWID  : NTT RAM word width, four coefficients per word
//   ADDWID : RAM address width
//   NCOEF  : coefficients per polynomial
//   NWORD  : RAM words per polynomial
//   unload_state_e : unload controller state encoding
package poly_pkg;

  localparam int unsigned WID    = 12;
  localparam int unsigned RDWID  = WID * 4;
  localparam int unsigned ADDWID = 5;
  localparam int unsigned NCOEF  = 128;
  localparam int unsigned NWORD  = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } unload_state_e;

endpackage

// File: rtl/poly_wordbuf.sv
// Two-word buffer feeding the coefficient stream.
// The hold word is emitted lane by lane (bits [WID-1:0] first). The next word
// is a prefetch slot that moves into hold on the same edge as the hold word's
// last lane handshake, so a full stream has no bubble.
// Ports:
//   clk         : clock
//   rst_ni      : synchronous active-low reset, empties both slots
//   wr_i        : RAM data on wr_data_i is valid this cycle
//   wr_data_i   : RAM read word
//   ready_i     : downstream accept
//   valid_o     : hold word present, data_o valid
//   data_o      : current lane of the hold word, 0 when not valid
//   next_full_o : prefetch slot occupied
//   last_hs_o   : handshake of the hold word's last lane this cycle
module poly_wordbuf #(
  parameter int unsigned WID   = poly_pkg::WID,
  parameter int unsigned RDWID = WID * 4
) (
  input  logic             clk,
  input  logic             rst_ni,
  input  logic             wr_i,
  input  logic [RDWID-1:0] wr_data_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WID-1:0]   data_o,
  output logic             next_full_o,
  output logic             last_hs_o
);

  logic [RDWID-1:0] hold_q, hold_d;
  logic [RDWID-1:0] next_q, next_d;
  logic             hold_v_q, hold_v_d;
  logic             next_v_q, next_v_d;
  logic [1:0]       lane_q, lane_d;
  logic             hs;
  logic             pop;

  assign hs  = hold_v_q & ready_i;
  assign pop = hs & (lane_q == 2'd3);

  always_comb begin
    hold_d   = hold_q;
    next_d   = next_q;
    hold_v_d = hold_v_q;
    next_v_d = next_v_q;
    lane_d   = lane_q;
    // Lane counter wraps to 0 after lane 3, ready for the following word.
    if (hs) lane_d = lane_q + 2'd1;
    if (!hold_v_q || pop) begin
      // Hold is free at this edge: refill from prefetch first, else directly
      // from the arriving RAM word. A RAM word arriving while prefetch is
      // promoted takes the prefetch slot.
      if (next_v_q) begin
        hold_d   = next_q;
        hold_v_d = 1'b1;
        next_v_d = 1'b0;
        lane_d   = '0;
        if (wr_i) begin
          next_d   = wr_data_i;
          next_v_d = 1'b1;
        end
      end else if (wr_i) begin
        hold_d   = wr_data_i;
        hold_v_d = 1'b1;
        lane_d   = '0;
      end else begin
        hold_v_d = 1'b0;
      end
    end else if (wr_i) begin
      next_d   = wr_data_i;
      next_v_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      hold_q   <= '0;
      next_q   <= '0;
      hold_v_q <= 1'b0;
      next_v_q <= 1'b0;
      lane_q   <= '0;
    end else begin
      hold_q   <= hold_d;
      next_q   <= next_d;
      hold_v_q <= hold_v_d;
      next_v_q <= next_v_d;
      lane_q   <= lane_d;
    end
  end

  always_comb begin
    data_o = '0;
    if (hold_v_q) begin
      case (lane_q)
        2'd0:    data_o = hold_q[WID-1:0];
        2'd1:    data_o = hold_q[2*WID-1:WID];
        2'd2:    data_o = hold_q[3*WID-1:2*WID];
        default: data_o = hold_q[4*WID-1:3*WID];
      endcase
    end
  end

  assign valid_o     = hold_v_q;
  assign next_full_o = next_v_q;
  assign last_hs_o   = pop;

endmodule

// File: rtl/poly_unload.sv
// Unloads one polynomial (NWORD RAM words, four coefficients each) from the
// NTT RAM as a valid/ready coefficient stream, words in ascending address order.
// Ports:
//   clk        : clock
//   rst        : synchronous active-low reset
//   start      : request one full unload (accepted only in IDLE)
//   re, ra     : RAM read enable / address; data returns on rdo one cycle later
//   rdo        : RAM read data
//   coef_out   : current coefficient, 0 when coef_valid is low
//   coef_valid : coef_out valid
//   coef_ready : downstream accept
//   busy       : unload in progress
//   done       : one-cycle pulse after the final coefficient handshake
module poly_unload #(
  parameter int unsigned WID    = poly_pkg::WID,
  parameter int unsigned RDWID  = WID * 4,
  parameter int unsigned ADDWID = poly_pkg::ADDWID
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              re,
  output logic [ADDWID-1:0] ra,
  input  logic [RDWID-1:0]  rdo,
  output logic [WID-1:0]    coef_out,
  output logic              coef_valid,
  input  logic              coef_ready,
  output logic              busy,
  output logic              done
);

  import poly_pkg::*;

  localparam logic [ADDWID-1:0] PENULT_ADDR = ADDWID'(NWORD - 2);

  unload_state_e     state_q;
  logic              re_q;
  logic              rvalid_q;
  logic [ADDWID-1:0] ra_q;
  logic              busy_q;
  logic              done_q;

  logic next_full;
  logic last_hs;
  logic no_flight;
  logic issue;
  logic finish;

  // A read is in flight from the cycle re is high until its data is captured.
  assign no_flight = !re_q && !rvalid_q;
  assign issue     = (state_q == RUN) && !next_full && no_flight;
  // Final handshake: last lane popped with nothing buffered or in flight.
  assign finish    = (state_q == DRAIN) && last_hs && !next_full && no_flight;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      re_q     <= 1'b0;
      rvalid_q <= 1'b0;
      ra_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      re_q     <= 1'b0;
      done_q   <= 1'b0;
      rvalid_q <= re_q;
      case (state_q)
        IDLE: begin
          // The read of address 0 is issued on the accepting edge.
          if (start) begin
            state_q <= RUN;
            re_q    <= 1'b1;
            ra_q    <= '0;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          if (issue) begin
            re_q <= 1'b1;
            ra_q <= ra_q + 1'b1;
            if (ra_q == PENULT_ADDR) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (finish) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  poly_wordbuf #(
    .WID   (WID),
    .RDWID (RDWID)
  ) u_wordbuf (
    .clk         (clk),
    .rst_ni      (rst),
    .wr_i        (rvalid_q),
    .wr_data_i   (rdo),
    .ready_i     (coef_ready),
    .valid_o     (coef_valid),
    .data_o      (coef_out),
    .next_full_o (next_full),
    .last_hs_o   (last_hs)
  );

  assign re   = re_q;
  assign ra   = ra_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_poly_unload.sv
// Directed bench for poly_unload. RAM word k holds {4k+3, 4k+2, 4k+1, 4k},
// so the expected coefficient stream is simply 0,1,...,127.
module tb_poly_unload;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        re;
  logic [4:0]  ra;
  logic [47:0] rdo = '0;
  logic [11:0] coef_out;
  logic        coef_valid;
  logic        coef_ready;
  logic        busy;
  logic        done;

  int nvec = 0;
  int nerr = 0;

  poly_unload dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .re         (re),
    .ra         (ra),
    .rdo        (rdo),
    .coef_out   (coef_out),
    .coef_valid (coef_valid),
    .coef_ready (coef_ready),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  function automatic logic [47:0] word(input logic [4:0] k);
    int b;
    b = 4 * int'(k);
    return {12'(b + 3), 12'(b + 2), 12'(b + 1), 12'(b)};
  endfunction

  // RAM model: one-cycle read latency.
  always @(posedge clk) if (re) rdo <= word(ra);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b1; coef_ready = 1'b1;
    step(); step(); step();
    nvec++; if (re !== 1'b0)         begin nerr++; $display("FAIL reset_re got %0b want 0", re); end
    nvec++; if (ra !== 5'd0)         begin nerr++; $display("FAIL reset_ra got %0d want 0", ra); end
    nvec++; if (coef_out !== 12'd0)  begin nerr++; $display("FAIL reset_coef_out got %0d want 0", coef_out); end
    nvec++; if (coef_valid !== 1'b0) begin nerr++; $display("FAIL reset_coef_valid got %0b want 0", coef_valid); end
    nvec++; if (busy !== 1'b0)       begin nerr++; $display("FAIL reset_busy got %0b want 0", busy); end
    nvec++; if (done !== 1'b0)       begin nerr++; $display("FAIL reset_done got %0b want 0", done); end
    rst = 1'b1; start = 1'b0;
    step();
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset_start_ignored busy got %0b want 0", busy); end
    nvec++; if (re !== 1'b0)   begin nerr++; $display("FAIL reset_start_ignored re got %0b want 0", re); end
  endtask

  task automatic test_stream();
    coef_ready = 1'b1; start = 1'b1;
    step(); start = 1'b0;                      // cycle T+1
    nvec++; if (re !== 1'b1)   begin nerr++; $display("FAIL stream_first_re got %0b want 1", re); end
    nvec++; if (ra !== 5'd0)   begin nerr++; $display("FAIL stream_first_ra got %0d want 0", ra); end
    nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL stream_busy got %0b want 1", busy); end
    step();                                    // cycle T+2
    nvec++; if (coef_valid !== 1'b0) begin nerr++; $display("FAIL stream_early_valid got %0b want 0", coef_valid); end
    nvec++; if (coef_out !== 12'd0)  begin nerr++; $display("FAIL stream_early_out got %0d want 0", coef_out); end
    step();                                    // cycle T+3
    for (int i = 0; i < 128; i++) begin
      nvec++;
      if (coef_valid !== 1'b1 || coef_out !== 12'(i)) begin
        nerr++; $display("FAIL stream_coef[%0d] got valid=%0b out=%0d want valid=1 out=%0d", i, coef_valid, coef_out, i);
      end
      if (i < 127) begin
        nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL stream_early_done at coef %0d", i); end
      end
      step();
    end
    // cycle T+131
    nvec++; if (done !== 1'b1)       begin nerr++; $display("FAIL stream_done got %0b want 1", done); end
    nvec++; if (busy !== 1'b0)       begin nerr++; $display("FAIL stream_busy_end got %0b want 0", busy); end
    nvec++; if (coef_valid !== 1'b0) begin nerr++; $display("FAIL stream_valid_end got %0b want 0", coef_valid); end
    step();
    nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL stream_done_pulse got %0b want 0", done); end
  endtask

  task automatic test_toggle();
    int hs_cnt = 0;
    int re_cnt = 0;
    int done_cnt = 0;
    logic prev_stall = 1'b0;
    logic prev_re = 1'b0;
    logic [11:0] prev_out = '0;
    start = 1'b1;
    step(); start = 1'b0;
    for (int cyc = 0; cyc < 600 && done_cnt == 0; cyc++) begin
      coef_ready = (cyc % 2 == 0);
      if (re) begin
        re_cnt++;
        nvec++; if (prev_re !== 1'b0) begin nerr++; $display("FAIL toggle_outstanding two reads back to back at ra=%0d", ra); end
      end
      if (prev_stall) begin
        nvec++;
        if (coef_valid !== 1'b1 || coef_out !== prev_out) begin
          nerr++; $display("FAIL toggle_stable got valid=%0b out=%0d want valid=1 out=%0d", coef_valid, coef_out, prev_out);
        end
      end
      if (coef_valid && coef_ready) begin
        nvec++; if (coef_out !== 12'(hs_cnt)) begin nerr++; $display("FAIL toggle_order got %0d want %0d", coef_out, hs_cnt); end
        hs_cnt++;
      end
      if (!coef_valid) begin
        nvec++; if (coef_out !== 12'd0) begin nerr++; $display("FAIL toggle_zero_when_invalid got %0d want 0", coef_out); end
      end
      if (done) done_cnt++;
      prev_stall = coef_valid && !coef_ready;
      prev_out   = coef_out;
      prev_re    = re;
      step();
    end
    nvec++; if (hs_cnt !== 128) begin nerr++; $display("FAIL toggle_handshakes got %0d want 128", hs_cnt); end
    nvec++; if (re_cnt !== 32)  begin nerr++; $display("FAIL toggle_reads got %0d want 32", re_cnt); end
    nvec++; if (done_cnt !== 1) begin nerr++; $display("FAIL toggle_done got %0d want 1", done_cnt); end
    coef_ready = 1'b1;
  endtask

  task automatic test_stall();
    int wait_cyc = 0;
    int re_cnt = 0;
    int hs_cnt = 0;
    int done_cnt = 0;
    logic [4:0] re_ra = '1;
    coef_ready = 1'b1; start = 1'b1;
    step(); start = 1'b0;                      // cycle T+1
    while (!coef_valid && wait_cyc < 10) begin
      wait_cyc++;
      step();
    end
    nvec++; if (wait_cyc !== 2) begin nerr++; $display("FAIL stall_first_valid_latency got %0d want 2", wait_cyc); end
    coef_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      nvec++;
      if (coef_valid !== 1'b1 || coef_out !== 12'd0) begin
        nerr++; $display("FAIL stall_hold[%0d] got valid=%0b out=%0d want valid=1 out=0", i, coef_valid, coef_out);
      end
      if (re) begin re_cnt++; re_ra = ra; end
      step();
    end
    nvec++; if (re_cnt !== 1)  begin nerr++; $display("FAIL stall_reads got %0d want 1", re_cnt); end
    nvec++; if (re_ra !== 5'd1) begin nerr++; $display("FAIL stall_prefetch_ra got %0d want 1", re_ra); end
    coef_ready = 1'b1;
    for (int i = 0; i < 300 && done_cnt == 0; i++) begin
      if (coef_valid && coef_ready) begin
        nvec++; if (coef_out !== 12'(hs_cnt)) begin nerr++; $display("FAIL stall_resume got %0d want %0d", coef_out, hs_cnt); end
        hs_cnt++;
      end
      if (done) done_cnt++;
      step();
    end
    nvec++; if (hs_cnt !== 128) begin nerr++; $display("FAIL stall_handshakes got %0d want 128", hs_cnt); end
    nvec++; if (done_cnt !== 1) begin nerr++; $display("FAIL stall_done got %0d want 1", done_cnt); end
  endtask

  task automatic test_restart_ignored();
    int hs_cnt = 0;
    int done_cnt = 0;
    coef_ready = 1'b1; start = 1'b1;
    step();
    for (int cyc = 0; cyc < 200; cyc++) begin
      start = (cyc == 10 || cyc == 60);
      if (coef_valid && coef_ready) begin
        nvec++; if (coef_out !== 12'(hs_cnt)) begin nerr++; $display("FAIL restart_order got %0d want %0d", coef_out, hs_cnt); end
        hs_cnt++;
      end
      if (done) done_cnt++;
      step();
    end
    start = 1'b0;
    nvec++; if (hs_cnt !== 128) begin nerr++; $display("FAIL restart_coefs got %0d want 128", hs_cnt); end
    nvec++; if (done_cnt !== 1) begin nerr++; $display("FAIL restart_done got %0d want 1", done_cnt); end
    nvec++; if (busy !== 1'b0)  begin nerr++; $display("FAIL restart_busy_end got %0b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    int hs_cnt = 0;
    logic hit = 1'b0;
    coef_ready = 1'b1; start = 1'b1;
    step(); start = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      if (coef_valid && coef_ready && hs_cnt == 49) hit = 1'b1;
      else begin
        if (coef_valid && coef_ready) hs_cnt++;
        step();
      end
    end
    nvec++; if (hit !== 1'b1) begin nerr++; $display("FAIL midreset_reach_50th got %0d handshakes want 49 before", hs_cnt); end
    rst = 1'b0;                                // reset in the cycle of handshake 50
    step();
    nvec++; if (re !== 1'b0)         begin nerr++; $display("FAIL midreset_re got %0b want 0", re); end
    nvec++; if (ra !== 5'd0)         begin nerr++; $display("FAIL midreset_ra got %0d want 0", ra); end
    nvec++; if (coef_out !== 12'd0)  begin nerr++; $display("FAIL midreset_coef_out got %0d want 0", coef_out); end
    nvec++; if (coef_valid !== 1'b0) begin nerr++; $display("FAIL midreset_coef_valid got %0b want 0", coef_valid); end
    nvec++; if (busy !== 1'b0)       begin nerr++; $display("FAIL midreset_busy got %0b want 0", busy); end
    nvec++; if (done !== 1'b0)       begin nerr++; $display("FAIL midreset_done got %0b want 0", done); end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      nvec++;
      if (coef_valid !== 1'b0 || done !== 1'b0) begin
        nerr++; $display("FAIL midreset_discard[%0d] got valid=%0b done=%0b want 0 0", i, coef_valid, done);
      end
    end
    start = 1'b1;
    step(); start = 1'b0;
    nvec++; if (re !== 1'b1 || ra !== 5'd0) begin nerr++; $display("FAIL midreset_restart_read got re=%0b ra=%0d want re=1 ra=0", re, ra); end
    step(); step();
    nvec++;
    if (coef_valid !== 1'b1 || coef_out !== 12'd0) begin
      nerr++; $display("FAIL midreset_restart_first got valid=%0b out=%0d want valid=1 out=0", coef_valid, coef_out);
    end
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_back_to_back();
    int hs_cnt = 0;
    int done_cnt = 0;
    logic found = 1'b0;
    coef_ready = 1'b1; start = 1'b1;
    step();
    for (int i = 0; i < 300 && !found; i++) begin
      if (done) found = 1'b1;
      else step();
    end
    nvec++; if (found !== 1'b1) begin nerr++; $display("FAIL b2b_first_done got 0 want 1"); end
    step(); start = 1'b0;                      // one cycle after done
    nvec++; if (re !== 1'b1)   begin nerr++; $display("FAIL b2b_re got %0b want 1", re); end
    nvec++; if (ra !== 5'd0)   begin nerr++; $display("FAIL b2b_ra got %0d want 0", ra); end
    nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL b2b_busy got %0b want 1", busy); end
    step(); step();
    nvec++;
    if (coef_valid !== 1'b1 || coef_out !== 12'd0) begin
      nerr++; $display("FAIL b2b_first_coef got valid=%0b out=%0d want valid=1 out=0", coef_valid, coef_out);
    end
    for (int i = 0; i < 300 && done_cnt == 0; i++) begin
      if (coef_valid && coef_ready) begin
        nvec++; if (coef_out !== 12'(hs_cnt)) begin nerr++; $display("FAIL b2b_order got %0d want %0d", coef_out, hs_cnt); end
        hs_cnt++;
      end
      if (done) done_cnt++;
      step();
    end
    nvec++; if (hs_cnt !== 128) begin nerr++; $display("FAIL b2b_coefs got %0d want 128", hs_cnt); end
    nvec++; if (done_cnt !== 1) begin nerr++; $display("FAIL b2b_done got %0d want 1", done_cnt); end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; coef_ready = 1'b0;
    test_reset();
    test_stream();
    test_toggle();
    test_stall();
    test_restart_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/poly_unload.md
POLY_UNLOAD -- requirements
Module: poly_unload

Interface
REQ-001 Parameter WID, default 12, SHALL set the coefficient width in bits.
REQ-002 Parameter RDWID, default WID*4, SHALL set the NTT RAM word width (4 coefficients per word).
REQ-003 Parameter ADDWID, default 5, SHALL set the RAM address width (32 words).
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  SHALL be a synchronous, active-low reset, asserted when low and sampled on clk.
REQ-006 start  input  1  SHALL request one full polynomial unload (32 words, 128 coefficients).
REQ-007 re  output  1  SHALL be the RAM read enable.
REQ-008 ra  output  ADDWID  SHALL be the RAM read address.
REQ-009 rdo  input  RDWID  SHALL be RAM read data, valid exactly 1 cycle after re=1.
REQ-010 coef_out  output  WID  SHALL be the current output coefficient.
REQ-011 coef_valid  output  1  SHALL flag coef_out as valid.
REQ-012 coef_ready  input  1  SHALL be the downstream accept signal.
REQ-013 busy  output  1  SHALL be high from start acceptance until done is asserted.
REQ-014 done  output  1  SHALL be a one-cycle completion pulse.

Function
REQ-015 FSM states SHALL be IDLE, RUN, DRAIN; reset state IDLE.
REQ-016 IDLE->RUN on start=1; start SHALL be ignored in RUN and DRAIN.
REQ-017 RUN->DRAIN once the read of address 31 is issued; DRAIN->IDLE on the handshake of coefficient 127, with done=1 in the following cycle.
REQ-018 Word order SHALL be address 0..31 ascending; ra SHALL wrap to 0 only at the next start.
REQ-019 Lane order within a word SHALL be bits [WID-1:0] first, then [2WID-1:WID], [3WID-1:2WID], [4WID-1:3WID] (u20, v20, u21, v21).
REQ-020 Buffering SHALL be two words: a hold word (being emitted) and a next word (prefetched).
REQ-021 A read SHALL be issued when the next slot is empty, no read is in flight and words remain; at most one read SHALL be outstanding.
REQ-022 When the hold word's last lane completes its handshake, the next word (if present) SHALL move into hold in the same cycle, with no bubble.
REQ-023 A handshake SHALL occur when coef_valid=1 and coef_ready=1; the lane counter (2 bits) advances only on a handshake.
REQ-024 While coef_valid=1 and coef_ready=0, coef_out and coef_valid SHALL stay stable.
REQ-025 Latency: with start sampled at cycle T, re=1 and ra=0 SHALL occur at T+1, and the first coef_valid at T+3.
REQ-026 With coef_ready held at 1, coefficients SHALL stream on 128 consecutive cycles (T+3..T+130), with done at T+131.
REQ-027 start arriving in the same cycle as done SHALL be accepted (a back-to-back unload).
REQ-028 coef_out SHALL be 0 whenever coef_valid=0.

Reset
REQ-029 On rst=0 all outputs SHALL be 0 (re, ra, coef_out, coef_valid, busy, done) and the state SHALL be IDLE.
REQ-030 Reset mid-unload SHALL abort immediately: buffers are emptied, any in-flight read data is discarded, and no done pulse is produced.
REQ-031 A start sampled while rst=0 SHALL be ignored.

Structure
REQ-032 Shared package poly_pkg SHALL hold WID, RDWID, ADDWID, NCOEF=128, NWORD=32, and the unload state encoding.
REQ-033 The two-word buffer with its lane mux SHALL be one sub-module, poly_wordbuf; the FSM and address counter remain in poly_unload.

Verification
REQ-034 RAM word k = {4k+3, 4k+2, 4k+1, 4k}, coef_ready=1, start at T: coef_out = 0,1,...,127 on T+3..T+130; done at T+131; busy low at T+131.
REQ-035 Same data with coef_ready toggling 1,0,1,0: exactly 128 handshakes in order 0..127, stable outputs while stalled, at most one read outstanding.
REQ-036 coef_ready=0 for 20 cycles after the first valid: coef_out holds 0, re issues only the prefetch of address 1, then the stream resumes 0,1,2...
REQ-037 start pulsed again during RUN: ignored; exactly one done and 128 coefficients.
REQ-038 rst=0 at the 50th handshake: next cycle all outputs are 0; a new start yields the first coef_out=0 at start+3.
REQ-039 start held high across done: a second full unload begins, with re=1, ra=0 one cycle after done.
